// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and the USB-side
// ACK/RESEND transmitter.
package uart_pkg;

    localparam logic [7:0] ACK    = 8'hAA;
    localparam logic [7:0] RESEND = 8'hCC;

    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: flop-array circular byte buffer with wrapping pointers.
// A push into a full buffer is accepted only if a pop happens in the same
// cycle. A pop from an empty buffer is ignored.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_BITS-1:0]         din,
    input  logic                         pop,
    output logic [DATA_BITS-1:0]         dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(FIFO_DEPTH):0]  count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_recv.sv
// uart_recv: UART receiver. Deserializes 8N1 frames from USB_RX using an
// OVERSAMPLE-times sampling clock, checks framing, buffers bytes in
// uart_rx_fifo and presents them over valid/ready. USB_CTS (active low)
// asks the host to pause while the buffer is nearly full.
// Macro UART_RECV_PARITY_EN: frames carry an even parity bit (8E1) and
// parity_err becomes live; without it parity_err is constant 0.
module uart_recv
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 USB_RX,
    output logic                 USB_CTS,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [SW-1:0] SC_ONE    = SW'(1);
    localparam logic [SW-1:0] SC_MID    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_END    = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BC_ONE    = BW'(1);
    localparam logic [BW-1:0] BC_LAST   = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] CTS_LEVEL = CW'(FIFO_DEPTH - 1);

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] sh;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CW-1:0]        fifo_count;
`ifdef UART_RECV_PARITY_EN
    logic                 perr;
`endif

    assign rx_valid = ~fifo_empty;
    assign pop      = rx_valid & rx_ready;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= USB_RX;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: start-bit qualification, bit-centre sampling, stop check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            scnt       <= '0;
            bcnt       <= '0;
            sh         <= '0;
            push       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            perr       <= 1'b0;
`endif
        end else begin
            push       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        scnt  <= SC_ONE;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (scnt == SC_MID) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            scnt  <= '0;
                            bcnt  <= '0;
                            state <= S_DATA;
`ifdef UART_RECV_PARITY_EN
                            perr  <= 1'b0;
`endif
                        end
                    end else begin
                        scnt <= scnt + SC_ONE;
                    end
                end
                S_DATA: begin
                    if (scnt == SC_END) begin
                        scnt <= '0;
                        sh   <= {rx_s, sh[DATA_BITS-1:1]};
                        if (bcnt == BC_LAST) begin
`ifdef UART_RECV_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bcnt <= bcnt + BC_ONE;
                        end
                    end else begin
                        scnt <= scnt + SC_ONE;
                    end
                end
`ifdef UART_RECV_PARITY_EN
                S_PARITY: begin
                    if (scnt == SC_END) begin
                        scnt  <= '0;
                        perr  <= (rx_s != ^sh);
                        state <= S_STOP;
                    end else begin
                        scnt <= scnt + SC_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (scnt == SC_END) begin
                        scnt <= '0;
                        if (rx_s) begin
`ifdef UART_RECV_PARITY_EN
                            if (perr) begin
                                parity_err <= 1'b1;
                            end else begin
                                push <= 1'b1;
                            end
`else
                            push <= 1'b1;
`endif
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        scnt <= scnt + SC_ONE;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Overrun pulse and registered flow control toward the host.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            USB_CTS <= 1'b1;
        end else begin
            overrun <= push & fifo_full & ~pop;
            USB_CTS <= (fifo_count >= CTS_LEVEL);
        end
    end

    uart_rx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sh),
        .pop   (pop),
        .dout  (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: self-checking bench for uart_recv. Frames are built from
// bytes with plain arithmetic; a queue model tracks which bytes should be
// delivered and which error pulses should appear.
// Honours UART_RECV_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_uart_recv;
    import uart_pkg::*;

    localparam int OS    = 16;
    localparam int DEPTH = 4;
`ifdef UART_RECV_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       USB_RX = 1'b1;
    logic       rx_ready = 1'b0;
    logic       USB_CTS;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt, ov_cnt, pe_cnt, valid_cycles;
    int exp_fe, exp_ov, exp_pe;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_recv #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .USB_RX     (USB_RX),
        .USB_CTS    (USB_CTS),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // Monitor: records accepted bytes and error pulses mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
            if (rx_valid === 1'b1) valid_cycles++;
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
            if (parity_err === 1'b1) pe_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        USB_RX = v;
        repeat (OS) tick();
    endtask

    function automatic logic even_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 1;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_BITS == 1) drive_bit(par);
        drive_bit(stop);
    endtask

    // Reference model: outcome of one frame given the current occupancy.
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
        if (!stop) exp_fe++;
        else if (PAR_BITS == 1 && par != even_par(b)) exp_pe++;
        else if (exp_q.size() - got_q.size() >= DEPTH) exp_ov++;
        else exp_q.push_back(b);
    endtask

    task automatic clear_stats();
        fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; valid_cycles = 0;
        exp_fe = 0; exp_ov = 0; exp_pe = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_ready = 1'b0;
        USB_RX = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        clear_stats();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_cmp++; if ({frame_err, overrun, parity_err} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {frame_err, overrun, parity_err}); end
        n_cmp++; if (USB_CTS !== 1'b1) begin n_bad++; $display("FAIL reset_cts: got %b want 1", USB_CTS); end
        n_cmp++; if (dut.state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, S_IDLE); end
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++; if (USB_CTS !== 1'b0) begin n_bad++; $display("FAIL cts_after_reset: got %b want 0", USB_CTS); end
        clear_stats();
    endtask

    task automatic test_basic();
        logic [7:0] g;
        clear_stats();
        rx_ready = 1'b1;
        model_frame(ACK, even_par(ACK), 1'b1);
        send_frame(ACK, even_par(ACK), 1'b1);
        repeat (4) tick();
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (g !== exp_q[0]) begin n_bad++; $display("FAIL basic_data: got %h want %h", g, exp_q[0]); end
        n_cmp++; if (valid_cycles != 1) begin n_bad++; $display("FAIL basic_valid_pulse: got %0d cycles want 1", valid_cycles); end
        n_cmp++; if (fe_cnt + ov_cnt + pe_cnt != 0) begin n_bad++; $display("FAIL basic_errors: got %0d want 0", fe_cnt + ov_cnt + pe_cnt); end
    endtask

    task automatic test_glitch();
        clear_stats();
        USB_RX = 1'b0;
        repeat (2) tick();
        USB_RX = 1'b1;
        repeat (8) tick();
        n_cmp++; if (dut.state !== S_IDLE) begin n_bad++; $display("FAIL glitch_state: got %0d want %0d", dut.state, S_IDLE); end
        repeat (40) tick();
        n_cmp++; if (valid_cycles != 0) begin n_bad++; $display("FAIL glitch_valid: got %0d want 0", valid_cycles); end
        n_cmp++; if (fe_cnt != 0) begin n_bad++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt); end
    endtask

    task automatic test_break();
        logic [7:0] g;
        clear_stats();
        rx_ready = 1'b1;
        model_frame(RESEND, even_par(RESEND), 1'b0);
        send_frame(RESEND, even_par(RESEND), 1'b0);
        USB_RX = 1'b0;
        repeat (40) tick();
        USB_RX = 1'b1;
        repeat (20) tick();
        n_cmp++; if (valid_cycles != 0) begin n_bad++; $display("FAIL break_no_push: got %0d want 0", valid_cycles); end
        model_frame(8'h55, even_par(8'h55), 1'b1);
        send_frame(8'h55, even_par(8'h55), 1'b1);
        repeat (4) tick();
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        n_cmp++; if (fe_cnt != exp_fe) begin n_bad++; $display("FAIL break_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL break_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (g !== exp_q[0]) begin n_bad++; $display("FAIL break_next_data: got %h want %h", g, exp_q[0]); end
        n_cmp++; if (pe_cnt != 0) begin n_bad++; $display("FAIL break_parity: got %0d want 0", pe_cnt); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] b;
        int occ;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            b = 8'(k);
            model_frame(b, even_par(b), 1'b1);
            send_frame(b, even_par(b), 1'b1);
            repeat (2) tick();
            occ = exp_q.size() - got_q.size();
            n_cmp++; if (USB_CTS !== (occ >= DEPTH - 1)) begin n_bad++; $display("FAIL cts_fill_%0d: got %b want %b", k, USB_CTS, occ >= DEPTH - 1); end
        end
        n_cmp++; if (ov_cnt != exp_ov) begin n_bad++; $display("FAIL overrun_count: got %0d want %0d", ov_cnt, exp_ov); end
        while (exp_q.size() > got_q.size()) begin
            n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp_q[got_q.size()]) begin n_bad++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", got_q.size(), rx_valid, rx_data, exp_q[got_q.size()]); end
            rx_ready = 1'b1; tick(); rx_ready = 1'b0; tick();
            occ = exp_q.size() - got_q.size();
            n_cmp++; if (USB_CTS !== (occ >= DEPTH - 1)) begin n_bad++; $display("FAIL cts_drain_%0d: got %b want %b", occ, USB_CTS, occ >= DEPTH - 1); end
        end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL drained_empty: got %b want 0", rx_valid); end
    endtask

    task automatic test_full_pop();
        logic [7:0] b;
        bit seen = 0;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            b = 8'(k);
            model_frame(b, even_par(b), 1'b1);
            send_frame(b, even_par(b), 1'b1);
        end
        repeat (2) tick();
        // Push and pop land on the same edge, so the new byte always fits.
        exp_q.push_back(8'd5);
        fork
            send_frame(8'd5, even_par(8'd5), 1'b1);
            begin
                for (int c = 0; c < 400; c++) begin
                    if (dut.push === 1'b1) begin
                        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
                        seen = 1;
                        break;
                    end
                    tick();
                end
            end
        join
        repeat (2) tick();
        n_cmp++; if (seen != 1'b1) begin n_bad++; $display("FAIL push_window: got %0d want 1", seen); end
        n_cmp++; if (ov_cnt != 0) begin n_bad++; $display("FAIL full_pop_overrun: got %0d want 0", ov_cnt); end
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL full_pop_first: got %0d pops want 1", got_q.size()); end
        for (int n = 0; n < 8 && exp_q.size() > got_q.size(); n++) begin
            n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp_q[got_q.size()]) begin n_bad++; $display("FAIL full_pop_drain_%0d: got v=%b d=%h want v=1 d=%h", got_q.size(), rx_valid, rx_data, exp_q[got_q.size()]); end
            rx_ready = 1'b1; tick(); rx_ready = 1'b0; tick();
        end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL full_pop_empty: got %b want 0", rx_valid); end
    endtask

`ifdef UART_RECV_PARITY_EN
    task automatic test_parity();
        logic [7:0] g;
        clear_stats();
        rx_ready = 1'b1;
        model_frame(ACK, ~even_par(ACK), 1'b1);
        send_frame(ACK, ~even_par(ACK), 1'b1);
        repeat (4) tick();
        n_cmp++; if (pe_cnt != exp_pe) begin n_bad++; $display("FAIL parity_err_count: got %0d want %0d", pe_cnt, exp_pe); end
        n_cmp++; if (valid_cycles != 0) begin n_bad++; $display("FAIL parity_no_push: got %0d want 0", valid_cycles); end
        model_frame(ACK, even_par(ACK), 1'b1);
        send_frame(ACK, even_par(ACK), 1'b1);
        repeat (4) tick();
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        n_cmp++; if (g !== exp_q[0]) begin n_bad++; $display("FAIL parity_good_data: got %h want %h", g, exp_q[0]); end
        n_cmp++; if (fe_cnt != 0 || pe_cnt != exp_pe) begin n_bad++; $display("FAIL parity_errors: got fe=%0d pe=%0d want fe=0 pe=%0d", fe_cnt, pe_cnt, exp_pe); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] b;
        logic [7:0] g;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom_range(0, 255));
            model_frame(b, even_par(b), 1'b1);
            send_frame(b, even_par(b), 1'b1);
        end
        repeat (2) tick();
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1", rx_valid); end
        drive_bit(1'b0);
        drive_bit(1'b1);
        USB_RX = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", rx_valid); end
        n_cmp++; if (USB_CTS !== 1'b1) begin n_bad++; $display("FAIL mid_reset_cts: got %b want 1", USB_CTS); end
        USB_RX = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        clear_stats();
        repeat (20) tick();
        rx_ready = 1'b1;
        b = 8'($urandom_range(0, 255));
        model_frame(b, even_par(b), 1'b1);
        send_frame(b, even_par(b), 1'b1);
        repeat (4) tick();
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL mid_after_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (g !== exp_q[0]) begin n_bad++; $display("FAIL mid_after_data: got %h want %h", g, exp_q[0]); end
        n_cmp++; if (fe_cnt != 0) begin n_bad++; $display("FAIL mid_after_frame_err: got %0d want 0", fe_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        int gap;
        clear_stats();
        rx_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom_range(0, 255));
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
            model_frame(b, even_par(b), 1'b1);
            send_frame(b, even_par(b), 1'b1);
            repeat (gap) tick();
        end
        repeat (4) tick();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stream_byte_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (fe_cnt + ov_cnt + pe_cnt != 0) begin n_bad++; $display("FAIL stream_errors: got %0d want 0", fe_cnt + ov_cnt + pe_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_fifo_full();
        test_full_pop();
`ifdef UART_RECV_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
